// File: rtl/pe_load_ctrl.sv
// pe_load_ctrl: streams a B vector into a PE's local RAM, then streams the
// A vector as MAC operands aligned with the RAM read latency. It collects N
// PE result strobes and captures the final dot-product result.
module pe_load_ctrl #(
    parameter int unsigned L_RAM_SIZE = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    output logic                  s_ready,
    output logic                  pe_aresetn,
    output logic [31:0]           pe_din,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [31:0]           pe_ain,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [31:0]           pe_dout,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result
);

    // The element index of the last word in each phase is N-1, which is all ones.
    localparam logic [L_RAM_SIZE-1:0] CNT_LAST = '1;
    localparam logic [L_RAM_SIZE:0]   DV_LAST  = {1'b0, {L_RAM_SIZE{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [L_RAM_SIZE-1:0]   cnt_q, cnt_d;
    logic [L_RAM_SIZE:0]     dv_cnt_q, dv_cnt_d;
    logic                    pe_aresetn_q, pe_aresetn_d;
    logic                    pe_we_q, pe_we_d;
    logic [L_RAM_SIZE-1:0]   pe_addr_q, pe_addr_d;
    logic [31:0]             pe_din_q, pe_din_d;
    // A-operand stage that waits one cycle for the PE RAM read data.
    logic                    stg_vld_q, stg_vld_d;
    logic [31:0]             stg_ain_q, stg_ain_d;
    logic                    pe_valid_q, pe_valid_d;
    logic [31:0]             pe_ain_q, pe_ain_d;
    logic                    done_q, done_d;
    logic [31:0]             result_q, result_d;
    logic                    beat;

    assign s_ready    = (state_q == S_LOAD) || (state_q == S_CALC);
    assign beat       = s_valid && s_ready;
    assign busy       = (state_q != S_IDLE);
    assign pe_aresetn = pe_aresetn_q;
    assign pe_we      = pe_we_q;
    assign pe_addr    = pe_addr_q;
    assign pe_din     = pe_din_q;
    assign pe_valid   = pe_valid_q;
    assign pe_ain     = pe_ain_q;
    assign done       = done_q;
    assign result     = result_q;

    // Next-state and registered-output logic for the load/compute sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dv_cnt_d     = dv_cnt_q;
        pe_aresetn_d = 1'b1;
        pe_we_d      = 1'b0;
        pe_addr_d    = pe_addr_q;
        pe_din_d     = pe_din_q;
        stg_vld_d    = 1'b0;
        stg_ain_d    = stg_ain_q;
        pe_valid_d   = stg_vld_q;
        pe_ain_d     = stg_vld_q ? stg_ain_q : pe_ain_q;
        done_d       = 1'b0;
        result_d     = result_q;

        // Result strobes only belong to this run once the A stream has begun.
        if (pe_dvalid && ((state_q == S_CALC) || (state_q == S_WAIT))) begin
            dv_cnt_d = dv_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    cnt_d        = '0;
                    dv_cnt_d     = '0;
                    pe_aresetn_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    pe_we_d   = 1'b1;
                    pe_addr_d = cnt_q;
                    pe_din_d  = s_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                    end
                end
            end
            S_CALC: begin
                if (beat) begin
                    pe_addr_d = cnt_q;
                    stg_vld_d = 1'b1;
                    stg_ain_d = s_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (pe_dvalid && (dv_cnt_q >= DV_LAST)) begin
                    result_d = pe_dout;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dv_cnt_q     <= '0;
            pe_aresetn_q <= 1'b0;
            pe_we_q      <= 1'b0;
            pe_addr_q    <= '0;
            pe_din_q     <= '0;
            stg_vld_q    <= 1'b0;
            stg_ain_q    <= '0;
            pe_valid_q   <= 1'b0;
            pe_ain_q     <= '0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dv_cnt_q     <= dv_cnt_d;
            pe_aresetn_q <= pe_aresetn_d;
            pe_we_q      <= pe_we_d;
            pe_addr_q    <= pe_addr_d;
            pe_din_q     <= pe_din_d;
            stg_vld_q    <= stg_vld_d;
            stg_ain_q    <= stg_ain_d;
            pe_valid_q   <= pe_valid_d;
            pe_ain_q     <= pe_ain_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

endmodule

// File: doc/pe_load_ctrl.md
PE_LOAD_CTRL -- requirements
Module: pe_load_ctrl

Interface
REQ-001 Parameter: L_RAM_SIZE, default 3, log2 of vector length N = 2**L_RAM_SIZE (PE local RAM depth).
REQ-002 aclk  in  1  sole clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle request to run one N-element dot product; honoured only in IDLE.
REQ-005 s_valid  in  1  input stream word valid.
REQ-006 s_data  in  32  input stream word; first N words = B vector, next N words = A vector.
REQ-007 s_ready  out  1  block accepts s_data; a beat transfers when s_valid && s_ready.
REQ-008 pe_aresetn  out  1  active-low clear to the downstream PE (clears its MAC accumulator).
REQ-009 pe_din  out  32  write data to PE local RAM.
REQ-010 pe_addr  out  L_RAM_SIZE  PE local RAM address (write or read).
REQ-011 pe_we  out  1  PE local RAM write enable.
REQ-012 pe_ain  out  32  A operand to PE MAC.
REQ-013 pe_valid  out  1  pe_ain valid, aligned with PE RAM read data.
REQ-014 pe_dvalid  in  1  PE result valid strobe.
REQ-015 pe_dout  in  32  PE result.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse; result valid.
REQ-018 result  out  32  captured dot-product result.

Function
REQ-019 Registered FSM with states IDLE, LOAD, CALC, WAIT, DONE; all pe_* outputs, done and result registered.
REQ-020 IDLE: s_ready=0, pe_we=0, pe_valid=0; start=1 -> LOAD, element counter cnt cleared, pe_aresetn driven 0 for exactly the next cycle.
REQ-021 start while not IDLE is ignored, no state change.
REQ-022 LOAD: s_ready=1; each beat -> next cycle pe_we=1, pe_addr=cnt, pe_din=s_data; cnt increments; cycles without beat -> pe_we=0.
REQ-023 LOAD: on N-th beat -> CALC, cnt cleared; pe_we never asserted outside LOAD-driven writes.
REQ-024 CALC: s_ready=1; beat in cycle t -> pe_addr=cnt, pe_we=0 in cycle t+1; pe_ain=s_data, pe_valid=1 in cycle t+2 (one-cycle delay matching PE RAM read latency).
REQ-025 CALC: stalls (s_valid=0) produce pe_valid=0 in the corresponding cycle; ordering preserved, no word dropped or duplicated.
REQ-026 CALC: on N-th beat -> WAIT; s_ready=0 from WAIT onward until next LOAD.
REQ-027 Result counter (width L_RAM_SIZE+1) counts pe_dvalid pulses in CALC and WAIT; pe_dvalid in IDLE, LOAD, DONE ignored.
REQ-028 WAIT: when N-th pe_dvalid seen, result <= pe_dout of that cycle, -> DONE.
REQ-029 DONE: done=1 for one cycle, -> IDLE; result holds until overwritten by next run.
REQ-030 cnt wraps modulo N for pe_addr; address N-1 is last written/read per phase.
REQ-031 Simultaneous start and DONE: start ignored (not IDLE); start in the following IDLE cycle accepted.

Reset
REQ-032 aresetn=0 at any edge: state=IDLE, cnt=0, dvalid count=0, s_ready=0, pe_we=0, pe_valid=0, pe_addr=0, pe_din=0, pe_ain=0, pe_aresetn=0, busy=0, done=0, result=0.
REQ-033 pe_aresetn returns to 1 on the first edge with aresetn=1; reset mid-run abandons the run, no done pulse.

Verification
REQ-034 N=8, start, 8 B words 1..8 back-to-back -> pe_we high 8 cycles, pe_addr 0..7, pe_din 1..8, then CALC.
REQ-035 Then A words all 2, back-to-back -> pe_valid 8 cycles, each 2 cycles after its beat, pe_addr 0..7 one cycle ahead; with model PE, result=72, done one pulse.
REQ-036 A stream with s_valid low every other cycle -> pe_valid gaps match, result unchanged (72).
REQ-037 start pulsed during LOAD and CALC -> ignored; pe_aresetn low exactly one cycle per accepted start.
REQ-038 aresetn low for one cycle mid-CALC -> all outputs at reset values next cycle, no done; fresh run afterwards gives correct result.
REQ-039 pe_dvalid pulses injected in IDLE/LOAD -> not counted; result captured only on 8th in-run pulse.
